// File: rtl/decode_regread.sv
// decode_regread: Y86-64 decode stage with register file read, writeback bypass and D->E pipeline register
module decode_regread #(
    parameter int         NREG         = 15,
    parameter logic [3:0] BUBBLE_ICODE = 4'h1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        d_valid,
    input  logic [3:0]  d_icode,
    input  logic [3:0]  d_ifun,
    input  logic [3:0]  d_ra,
    input  logic [3:0]  d_rb,
    input  logic [63:0] d_valc,
    input  logic [63:0] d_valp,
    input  logic        e_stall,
    input  logic        e_bubble,
    input  logic [3:0]  w_dste,
    input  logic [3:0]  w_dstm,
    input  logic [63:0] w_vale,
    input  logic [63:0] w_valm,
    output logic [3:0]  d_srca,
    output logic [3:0]  d_srcb,
    output logic [3:0]  e_icode,
    output logic [3:0]  e_ifun,
    output logic [3:0]  e_srca,
    output logic [3:0]  e_srcb,
    output logic [3:0]  e_dste,
    output logic [3:0]  e_dstm,
    output logic [63:0] e_vala,
    output logic [63:0] e_valb,
    output logic [63:0] e_valc,
    output logic        e_valid
);
    localparam logic [3:0] RNONE = 4'hF;
    localparam logic [3:0] RSP   = 4'h4;

    logic [63:0] regs [NREG];
    logic [3:0]  d_dste, d_dstm;
    logic [63:0] rd_a, rd_b, d_vala;

    function automatic logic [63:0] rd(input logic [3:0] s);
        return (s == RNONE) ? 64'd0 :
               (s == w_dstm) ? w_valm :
               (s == w_dste) ? w_vale : regs[s];
    endfunction

    always_comb begin
        d_srca = (d_icode inside {4'h2, 4'h4, 4'h6, 4'hA}) ? d_ra :
                 (d_icode inside {4'h9, 4'hB}) ? RSP : RNONE;
        d_srcb = (d_icode inside {4'h4, 4'h5, 4'h6}) ? d_rb :
                 (d_icode inside {4'h8, 4'h9, 4'hA, 4'hB}) ? RSP : RNONE;
        d_dste = (d_icode inside {4'h2, 4'h3, 4'h6}) ? d_rb :
                 (d_icode inside {4'h8, 4'h9, 4'hA, 4'hB}) ? RSP : RNONE;
        d_dstm = (d_icode inside {4'h5, 4'hB}) ? d_ra : RNONE;
        rd_a   = rd(d_srca);
        rd_b   = rd(d_srcb);
        d_vala = (d_icode inside {4'h7, 4'h8}) ? d_valp : rd_a;
    end

    // valM port is written last so it wins a same-register collision (popq %rsp)
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
        end else begin
            if (w_dste != RNONE) regs[w_dste] <= w_vale;
            if (w_dstm != RNONE) regs[w_dstm] <= w_valm;
        end
    end

    always_ff @(posedge clock) begin
        if (reset || e_bubble || (!e_stall && !d_valid)) begin
            e_icode <= BUBBLE_ICODE;
            e_ifun  <= '0;
            e_srca  <= RNONE;
            e_srcb  <= RNONE;
            e_dste  <= RNONE;
            e_dstm  <= RNONE;
            e_vala  <= '0;
            e_valb  <= '0;
            e_valc  <= '0;
            e_valid <= 1'b0;
        end else if (!e_stall) begin
            e_icode <= d_icode;
            e_ifun  <= d_ifun;
            e_srca  <= d_srca;
            e_srcb  <= d_srcb;
            e_dste  <= d_dste;
            e_dstm  <= d_dstm;
            e_vala  <= d_vala;
            e_valb  <= rd_b;
            e_valc  <= d_valc;
            e_valid <= 1'b1;
        end
    end
endmodule

// File: tb/tb_decode_regread.sv
// tb_decode_regread: directed self-checking bench for decode_regread
module tb_decode_regread;
    logic        clock = 0, reset = 0, d_valid = 0, e_stall = 0, e_bubble = 0;
    logic [3:0]  d_icode = 0, d_ifun = 0, d_ra = 4'hF, d_rb = 4'hF;
    logic [3:0]  w_dste = 4'hF, w_dstm = 4'hF;
    logic [63:0] d_valc = 0, d_valp = 0, w_vale = 0, w_valm = 0;
    logic [3:0]  d_srca, d_srcb, e_icode, e_ifun, e_srca, e_srcb, e_dste, e_dstm;
    logic [63:0] e_vala, e_valb, e_valc;
    logic        e_valid;
    int          checks = 0, errors = 0;

    decode_regread dut (
        .clock(clock), .reset(reset), .d_valid(d_valid), .d_icode(d_icode), .d_ifun(d_ifun),
        .d_ra(d_ra), .d_rb(d_rb), .d_valc(d_valc), .d_valp(d_valp), .e_stall(e_stall),
        .e_bubble(e_bubble), .w_dste(w_dste), .w_dstm(w_dstm), .w_vale(w_vale), .w_valm(w_valm),
        .d_srca(d_srca), .d_srcb(d_srcb), .e_icode(e_icode), .e_ifun(e_ifun), .e_srca(e_srca),
        .e_srcb(e_srcb), .e_dste(e_dste), .e_dstm(e_dstm), .e_vala(e_vala), .e_valb(e_valb),
        .e_valc(e_valc), .e_valid(e_valid)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic dec(input logic v, input logic [3:0] ic, input logic [3:0] ra, input logic [3:0] rb,
                       input logic [63:0] valc, input logic [63:0] valp);
        d_valid = v; d_icode = ic; d_ifun = 0; d_ra = ra; d_rb = rb; d_valc = valc; d_valp = valp;
    endtask

    task automatic wb(input logic [3:0] de, input logic [63:0] ve, input logic [3:0] dm, input logic [63:0] vm);
        w_dste = de; w_vale = ve; w_dstm = dm; w_valm = vm;
    endtask

    initial begin
        // reset with an active write port that must be ignored
        reset = 1; wb(4'h1, 64'hDEAD, 4'hF, 0); dec(1, 4'h6, 4'h1, 4'h2, 0, 0);
        step();
        chk("rst_icode", e_icode, 1); chk("rst_dste", e_dste, 4'hF); chk("rst_dstm", e_dstm, 4'hF);
        chk("rst_srca", e_srca, 4'hF); chk("rst_valid", e_valid, 0);
        reset = 0; wb(4'hF, 0, 4'hF, 0);
        dec(1, 4'h2, 4'h1, 4'h2, 0, 0);
        #1 chk("rrmov_dsrca", d_srca, 4'h1); chk("rrmov_dsrcb", d_srcb, 4'hF);
        step();
        chk("rrmov_vala", e_vala, 0); chk("rrmov_dste", e_dste, 4'h2); chk("rrmov_valid", e_valid, 1);

        // write r3, then read it through the array
        wb(4'h3, 64'h1234, 4'hF, 0); dec(0, 4'h0, 4'hF, 4'hF, 0, 0);
        step();
        wb(4'hF, 0, 4'hF, 0); dec(1, 4'h6, 4'h3, 4'h3, 0, 0);
        step();
        chk("opq_vala", e_vala, 64'h1234); chk("opq_valb", e_valb, 64'h1234);
        chk("opq_dste", e_dste, 4'h3); chk("opq_dstm", e_dstm, 4'hF);

        // same-cycle bypass with valM winning the collision
        wb(4'h4, 64'h100, 4'h4, 64'h200); dec(1, 4'hA, 4'h4, 4'hF, 0, 0);
        step();
        chk("push_vala", e_vala, 64'h200); chk("push_valb", e_valb, 64'h200); chk("push_dste", e_dste, 4'h4);
        wb(4'hF, 0, 4'hF, 0); dec(1, 4'h6, 4'h4, 4'h4, 0, 0);
        step();
        chk("r4_after_vala", e_vala, 64'h200); chk("r4_after_valb", e_valb, 64'h200);
        // valE bypass and valM bypass on different registers
        wb(4'h5, 64'h55, 4'h6, 64'h66); dec(1, 4'h6, 4'h5, 4'h6, 0, 0);
        step();
        chk("byp_e", e_vala, 64'h55); chk("byp_m", e_valb, 64'h66);

        // call
        wb(4'h4, 64'h1000, 4'hF, 0); dec(0, 4'h0, 4'hF, 4'hF, 0, 0);
        step();
        wb(4'hF, 0, 4'hF, 0); dec(1, 4'h8, 4'hF, 4'hF, 64'h99, 64'h40);
        step();
        chk("call_vala", e_vala, 64'h40); chk("call_valb", e_valb, 64'h1000);
        chk("call_dste", e_dste, 4'h4); chk("call_dstm", e_dstm, 4'hF); chk("call_valc", e_valc, 64'h99);

        // mrmovq, then stall while r4 is rewritten
        dec(1, 4'h5, 4'h7, 4'h4, 64'h8, 0);
        step();
        chk("mrm_valb", e_valb, 64'h1000); chk("mrm_dstm", e_dstm, 4'h7); chk("mrm_dste", e_dste, 4'hF);
        e_stall = 1; wb(4'h4, 64'h2222, 4'hF, 0); dec(1, 4'h6, 4'h1, 4'h2, 0, 0);
        step();
        wb(4'hF, 0, 4'hF, 0);
        step();
        chk("stall_icode", e_icode, 4'h5); chk("stall_valb", e_valb, 64'h1000);
        chk("stall_dstm", e_dstm, 4'h7); chk("stall_valc", e_valc, 64'h8);
        e_bubble = 1;
        step();
        chk("sb_icode", e_icode, 1); chk("sb_valid", e_valid, 0); chk("sb_srcb", e_srcb, 4'hF); chk("sb_valc", e_valc, 0);
        e_stall = 0; e_bubble = 0; dec(1, 4'h6, 4'h4, 4'h4, 0, 0);
        step();
        chk("stall_write", e_vala, 64'h2222);

        // invalid input and undefined icode
        dec(0, 4'h6, 4'h1, 4'h2, 0, 0);
        step();
        chk("inv_icode", e_icode, 1); chk("inv_valid", e_valid, 0); chk("inv_dste", e_dste, 4'hF);
        dec(1, 4'hE, 4'h1, 4'h2, 0, 0);
        #1 chk("undef_dsrca", d_srca, 4'hF); chk("undef_dsrcb", d_srcb, 4'hF);
        step();
        chk("undef_dste", e_dste, 4'hF); chk("undef_dstm", e_dstm, 4'hF); chk("undef_icode", e_icode, 4'hE);

        // popq, then reset mid-stream
        dec(1, 4'hB, 4'h3, 4'hF, 0, 0);
        #1 chk("pop_dsrca", d_srca, 4'h4);
        step();
        chk("pop_dstm", e_dstm, 4'h3); chk("pop_dste", e_dste, 4'h4); chk("pop_vala", e_vala, 64'h2222);
        reset = 1;
        step();
        reset = 0;
        chk("mid_rst_icode", e_icode, 1); chk("mid_rst_valid", e_valid, 0);
        dec(1, 4'h6, 4'h3, 4'h4, 0, 0);
        step();
        chk("rst_clr_a", e_vala, 0); chk("rst_clr_b", e_valb, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
